cla8_share_ctrl: RTL and testbench
==================================

# cla8_share_ctrl

Sequencer/arbiter that shares one gate-level 8-bit carry-lookahead adder between two requesters. It is a synchronous wrapper around the purely combinational, delay-annotated CLA datapath. It grants one requester at a time and drives the adder operands from registers. It holds them stable for a programmable settle window, then captures sum and carry-out into result registers and pulses a per-requester done.

## Interface
- `WIDTH`, 8: operand/sum width; must match the attached CLA.
- `SETTLE`, 3: clock cycles the operands are held on the adder before capture; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  request level; held until the matching done pulse.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands for requester 0/1; sampled only at grant.
- `cin0`, `cin1`  in  1  carry-in for requester 0/1; sampled at grant.
- `cla_a`, `cla_b`  out  WIDTH  registered operands to the CLA.
- `cla_cin`  out  1  registered carry-in to the CLA.
- `cla_s`  in  WIDTH  CLA sum output.
- `cla_cout`  in  1  CLA carry-out.
- `gnt0`, `gnt1`  out  1  owner of the adder; one-hot or zero.
- `done0`, `done1`  out  1  one-cycle pulse; the result is valid in that cycle.
- `sum`  out  WIDTH  captured sum; holds until the next capture.
- `cout`  out  1  captured carry-out; holds until the next capture.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, SETTLE, DONE.
- IDLE, no request: stay in IDLE. Outputs `gnt*`/`done*` are 0.
- IDLE, any request: on the clock edge, pick the winner by round-robin.
  - Latch the winner's a/b/cin into `cla_a`/`cla_b`/`cla_cin`.
  - Set `gnt` for the winner.
  - Load `cnt` = SETTLE-1 and go to SETTLE.
- Round-robin: 1-bit pointer `last` records the most recently served requester.
  - With both requests high, the requester not equal to `last` wins.
  - With one request high, that requester wins regardless of `last`.
  - Reset value of `last` is 1, so requester 0 wins the first tie.
- SETTLE:
  - While `cnt` != 0, decrement it.
  - When `cnt` == 0, capture `cla_s`→`sum` and `cla_cout`→`cout`, and go to DONE.
- DONE:
  - `done` for the granted requester is high and `gnt` stays high.
  - On the next edge, set `last` to the granted index, clear `gnt` and go to IDLE.
- Operands on `cla_*` change only at a grant edge. Between grants they hold their last value, so the CLA inputs never glitch during SETTLE.
- Requesters must drop `req` in the cycle after `done`. A `req` still high in IDLE is treated as a new request.
- `req*` and operand inputs are ignored in SETTLE and DONE. Changes there have no effect.
- Reset (async, any state): all of the following clear.
  - State goes to IDLE and `cnt` to 0.
  - `cla_a`/`cla_b`/`cla_cin`, `sum`/`cout`, `gnt*`, `done*` and `busy` go to 0.
  - `last` goes to 1.
  - An in-flight operation is discarded and produces no done.
- Addition width: `sum` equals (a+b+cin) mod 2^WIDTH and `cout` is bit WIDTH, as delivered by the CLA. The controller performs no arithmetic itself.

## Timing
- Grant at edge k (IDLE with a request):
  - Operands are on `cla_*` from k.
  - Capture happens at edge k+SETTLE.
  - `done` is high for the cycle between k+SETTLE and k+SETTLE+1.
  - State is back in IDLE after edge k+SETTLE+1.
- Latency from request seen in IDLE to done: SETTLE+1 cycles. Throughput: one operation per SETTLE+2 cycles.
- Settle window: the CLA has exactly SETTLE clock periods to settle. The clock period × SETTLE must exceed the worst-case gate delay of the CLA carry chain.
- SETTLE=1: capture on the edge immediately after grant. The SETTLE state lasts one cycle.
- `gnt` is high from edge k through the DONE cycle, i.e. SETTLE+1 cycles.
- `busy` rises at k and falls at k+SETTLE+1.

## Test plan
- Single op, SETTLE=3: req0 with a0=0x5A, b0=0x3C, cin0=0, grant at edge k → `done0` high in cycle k+3..k+4, `sum`=0x96, `cout`=0. `gnt1` and `done1` stay 0.
- Carry out through the full chain: req1 with a1=0xFF, b1=0x00, cin1=1 → `sum`=0x00, `cout`=1. `sum`/`cout` then hold unchanged for 10 idle cycles.
- Simultaneous, held requests after reset: req0 and req1 both high, each dropped after its done → order is 0 then 1. The second grant occurs exactly SETTLE+2 cycles after the first. The CLA is driven with the correct operands each time.
- Fairness: both requests reasserted continuously for 6 operations → grants alternate 0,1,0,1,0,1. `gnt0` and `gnt1` are never high together.
- Reset mid-SETTLE: assert `rst_n`=0 one cycle after grant → all outputs are 0 immediately (async). No done follows. After release with req1 only, `gnt1` is granted.
- SETTLE=1 corner, with the delay-annotated CLA and clock period above the carry-chain delay: 0x80+0x80, cin=0 → `sum`=0x00, `cout`=1, `done` two cycles after the request is seen.

Source files
------------

// File: rtl/cla8_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla8_share_ctrl
// Purpose  : Shares one combinational carry-lookahead adder between two
//            requesters. The winner's operands are registered onto the adder
//            inputs. They are held for SETTLE cycles while the carry chain
//            settles. The sum and carry-out are then captured and a one-cycle
//            done pulse is returned to the winner.
// Ports    : clk, rst_n              clock, async active-low reset
//            req0/req1               request levels
//            a0,b0,cin0 / a1,b1,cin1 operands, sampled at grant
//            cla_a, cla_b, cla_cin   registered operands to the CLA
//            cla_s, cla_cout         CLA result
//            gnt0/gnt1, done0/done1  grant level / completion pulse
//            sum, cout               captured result
//            busy                    high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module cla8_share_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic [WIDTH-1:0] cla_a,
  output logic [WIDTH-1:0] cla_b,
  output logic             cla_cin,
  input  logic [WIDTH-1:0] cla_s,
  input  logic             cla_cout,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int         CNT_W    = 4;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;   // most recently served requester
  logic               sel_q, sel_d;     // requester owning the current op
  logic [WIDTH-1:0]   cla_a_q, cla_a_d;
  logic [WIDTH-1:0]   cla_b_q, cla_b_d;
  logic               cla_cin_q, cla_cin_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               win;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    cla_a_d   = cla_a_q;
    cla_b_d   = cla_b_q;
    cla_cin_d = cla_cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    busy_d    = busy_q;
    // On a tie the requester not served last wins; a lone request always wins.
    win       = (req0 && req1) ? ~last_q : req1;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          sel_d     = win;
          cla_a_d   = win ? a1   : a0;
          cla_b_d   = win ? b1   : b0;
          cla_cin_d = win ? cin1 : cin0;
          gnt0_d    = ~win;
          gnt1_d    = win;
          cnt_d     = CNT_LOAD;
          busy_d    = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Operands have been stable on the CLA for SETTLE full periods.
          sum_d   = cla_s;
          cout_d  = cla_cout;
          done0_d = ~sel_q;
          done1_d = sel_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = sel_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      cla_a_q   <= '0;
      cla_b_q   <= '0;
      cla_cin_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      cla_a_q   <= cla_a_d;
      cla_b_q   <= cla_b_d;
      cla_cin_q <= cla_cin_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
    end
  end

  assign cla_a   = cla_a_q;
  assign cla_b   = cla_b_q;
  assign cla_cin = cla_cin_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cla8_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla8_share_ctrl
// Purpose  : Self-checking bench for cla8_share_ctrl. One instance uses
//            SETTLE=3 and a second uses SETTLE=1. Each drives a
//            delay-annotated adder stub. Expected results come from plain
//            (a+b+cin) arithmetic and a round-robin model of the
//            arbitration rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla8_share_ctrl;

  localparam int S = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   misses = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance with SETTLE = 3 ----------------
  logic       req0 = 0, req1 = 0, cin0 = 0, cin1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [7:0] cla_a, cla_b, sum;
  logic       cla_cin, cout, gnt0, gnt1, done0, done1, busy;
  wire  [8:0] cla_res;
  assign #2 cla_res = {1'b0, cla_a} + {1'b0, cla_b} + {8'd0, cla_cin};

  cla8_share_ctrl #(.WIDTH(8), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_s(cla_res[7:0]), .cla_cout(cla_res[8]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .sum(sum), .cout(cout), .busy(busy)
  );

  // ---------------- instance with SETTLE = 1 ----------------
  logic       s1_req0 = 0, s1_req1 = 0, s1_cin0 = 0, s1_cin1 = 0;
  logic [7:0] s1_a0 = 0, s1_b0 = 0, s1_a1 = 0, s1_b1 = 0;
  logic [7:0] s1_cla_a, s1_cla_b, s1_sum;
  logic       s1_cla_cin, s1_cout, s1_gnt0, s1_gnt1, s1_done0, s1_done1, s1_busy;
  wire  [8:0] s1_cla_res;
  assign #2 s1_cla_res = {1'b0, s1_cla_a} + {1'b0, s1_cla_b} + {8'd0, s1_cla_cin};

  cla8_share_ctrl #(.WIDTH(8), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .req0(s1_req0), .req1(s1_req1),
    .a0(s1_a0), .b0(s1_b0), .a1(s1_a1), .b1(s1_b1), .cin0(s1_cin0), .cin1(s1_cin1),
    .cla_a(s1_cla_a), .cla_b(s1_cla_b), .cla_cin(s1_cla_cin),
    .cla_s(s1_cla_res[7:0]), .cla_cout(s1_cla_res[8]),
    .gnt0(s1_gnt0), .gnt1(s1_gnt1), .done0(s1_done0), .done1(s1_done1),
    .sum(s1_sum), .cout(s1_cout), .busy(s1_busy)
  );

  // Reference state: most recently served requester and last grant cycle.
  logic m_last = 1'b1;
  int   prev_grant = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
    a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
  endtask

  // One full transaction on the SETTLE=3 instance. Called at a negedge while
  // the controller is idle and the requests for this op are already driven.
  task automatic op(input bit drop, input bit spacing);
    logic       exp_id;
    logic [7:0] ea, eb;
    logic       ec;
    logic [8:0] er;
    logic [1:0] eg;
    int         n;
    int         g;
    exp_id = (req0 && req1) ? ~m_last : req1;
    ea = exp_id ? a1 : a0;
    eb = exp_id ? b1 : b0;
    ec = exp_id ? cin1 : cin0;
    er = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
    eg = exp_id ? 2'b10 : 2'b01;
    n = 0;
    @(negedge clk);
    while (!(gnt0 || gnt1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    g = cyc;
    if (spacing) chk("grant_spacing", 32'(g - prev_grant), 32'(S + 2));
    chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});
    chk("cla_a", {24'd0, cla_a}, {24'd0, ea});
    chk("cla_b", {24'd0, cla_b}, {24'd0, eb});
    chk("cla_cin", {31'd0, cla_cin}, {31'd0, ec});
    chk("busy_hi", {31'd0, busy}, 32'd1);
    for (int i = 0; i < S - 1; i++) begin
      @(negedge clk);
      chk("early_done", {30'd0, done1, done0}, 32'd0);
      chk("gnt_hold", {30'd0, gnt1, gnt0}, {30'd0, eg});
      chk("cla_a_hold", {24'd0, cla_a}, {24'd0, ea});
    end
    @(negedge clk);
    chk("done", {30'd0, done1, done0}, {30'd0, eg});
    chk("gnt_done", {30'd0, gnt1, gnt0}, {30'd0, eg});
    chk("sum", {24'd0, sum}, {24'd0, er[7:0]});
    chk("cout", {31'd0, cout}, {31'd0, er[8]});
    if (drop) begin
      if (exp_id) req1 = 1'b0;
      else        req0 = 1'b0;
    end
    @(negedge clk);
    chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("idle_done", {30'd0, done1, done0}, 32'd0);
    chk("busy_lo", {31'd0, busy}, 32'd0);
    m_last = exp_id;
    prev_grant = g;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
  endtask

  initial begin
    logic [8:0] er;
    logic       r0, r1;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk("rst_outputs", {1'b0, cla_a, cla_b, cla_cin, sum, cout, gnt0, gnt1, done0, done1, busy}, 32'd0);
    chk("rst_outputs_s1", {1'b0, s1_cla_a, s1_cla_b, s1_cla_cin, s1_sum, s1_cout,
                           s1_gnt0, s1_gnt1, s1_done0, s1_done1, s1_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single op from requester 0: 0x5A + 0x3C.
    a0 = 8'h5A; b0 = 8'h3C; cin0 = 1'b0; req0 = 1'b1;
    op(1'b1, 1'b0);

    // Full carry chain from requester 1, then result hold while idle.
    a1 = 8'hFF; b1 = 8'h00; cin1 = 1'b1; req1 = 1'b1;
    op(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_sum", {24'd0, sum}, 32'd0);
      chk("hold_cout", {31'd0, cout}, 32'd1);
    end

    // Both requests right after reset: requester 0 first, then 1.
    do_reset();
    rand_ops();
    req0 = 1'b1; req1 = 1'b1;
    op(1'b1, 1'b0);
    op(1'b1, 1'b1);

    // Fairness with both requests held continuously.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      op(1'b0, i > 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Reset one cycle after grant: everything clears immediately.
    rand_ops();
    req0 = 1'b1;
    @(negedge clk);
    chk("pre_rst_gnt0", {31'd0, gnt0}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {1'b0, cla_a, cla_b, cla_cin, sum, cout, gnt0, gnt1, done0, done1, busy}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {30'd0, done1, done0}, 32'd0);
    rst_n = 1'b1;
    m_last = 1'b1;
    rand_ops();
    req1 = 1'b1;
    op(1'b1, 1'b0);

    // Random request patterns, each pending request served to completion.
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r1 = 1'b1;
      req0 = r0; req1 = r1;
      op(1'b1, 1'b0);
      if (req0 || req1) op(1'b1, 1'b0);
    end

    // SETTLE=1: 0x80 + 0x80 captured on the edge after grant.
    s1_a0 = 8'h80; s1_b0 = 8'h80; s1_cin0 = 1'b0; s1_req0 = 1'b1;
    @(negedge clk);
    chk("s1_gnt", {30'd0, s1_gnt1, s1_gnt0}, 32'd1);
    chk("s1_cla_a", {24'd0, s1_cla_a}, 32'h80);
    @(negedge clk);
    chk("s1_done", {30'd0, s1_done1, s1_done0}, 32'd1);
    chk("s1_sum", {24'd0, s1_sum}, 32'd0);
    chk("s1_cout", {31'd0, s1_cout}, 32'd1);
    s1_req0 = 1'b0;
    @(negedge clk);
    chk("s1_idle", {29'd0, s1_gnt1, s1_gnt0, s1_busy}, 32'd0);

    // SETTLE=1 random ops from requester 1.
    for (int i = 0; i < 4; i++) begin
      s1_a1 = 8'($urandom); s1_b1 = 8'($urandom); s1_cin1 = 1'($urandom);
      er = {1'b0, s1_a1} + {1'b0, s1_b1} + {8'd0, s1_cin1};
      s1_req1 = 1'b1;
      @(negedge clk);
      chk("s1_rgnt", {30'd0, s1_gnt1, s1_gnt0}, 32'd2);
      @(negedge clk);
      chk("s1_rdone", {30'd0, s1_done1, s1_done0}, 32'd2);
      chk("s1_rsum", {23'd0, s1_cout, s1_sum}, {23'd0, er});
      s1_req1 = 1'b0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
`default_nettype wire
